// File: rtl/elock_pkg.sv
// Shared types and defaults for the e-lock key entry front end.
// Imported by the debouncer and the key_entry top.
package elock_pkg;

  localparam int CODE_W          = 4;
  localparam int DEF_DEB_CYCLES  = 1000;
  localparam int DEF_HOLD_CYCLES = 4;
  localparam int DEF_MAX_TRIES   = 3;
  localparam int DEF_LOCK_CYCLES = 50000;

  typedef enum logic [1:0] {
    IDLE,
    PRESENT,
    OPEN,
    LOCKOUT
  } state_e;

endpackage

// File: rtl/debounce.sv
// Two-flop synchronizer followed by a stability-count debouncer.
// The output only follows the input after DEB_CYCLES quiet samples.
module debounce
  import elock_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk0,
  input  logic reset,
  input  logic raw_i,
  output logic stable_o
);

  localparam int CW =
    (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX =
    CW'(DEB_CYCLES - 1);

  logic          s1_q;
  logic          s2_q;
  logic          prev_q;
  logic          out_q;
  logic [CW-1:0] cnt_q;

  // Sync, restart the count on any change, accept once quiet.
  always_ff @(posedge clk0) begin
    if (!reset) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
      out_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      s1_q   <= raw_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
      if (s2_q != prev_q) begin
        cnt_q <= '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + 1'b1;
      end else begin
        out_q <= s2_q;
      end
    end
  end

  assign stable_o = out_q;

endmodule

// File: rtl/key_entry.sv
// Code-entry front end for the e-lock comparator: debounced inputs,
// timed confirm window, failure counting, lockout and re-programming.
module key_entry
  import elock_pkg::*;
#(
  parameter int DEB_CYCLES  = DEF_DEB_CYCLES,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int MAX_TRIES   = DEF_MAX_TRIES,
  parameter int LOCK_CYCLES = DEF_LOCK_CYCLES
) (
  input  logic              clk0,
  input  logic              reset,
  input  logic [CODE_W-1:0] sw,
  input  logic              btn_confirm,
  input  logic              btn_set,
  input  logic              succ,
  input  logic              defeat,
  output logic [CODE_W-1:0] code,
  output logic              yes,
  output logic              set,
  output logic              endmodi,
  output logic              open,
  output logic              locked_out,
  output logic [2:0]        fails
);

  localparam int HW =
    (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int LW =
    (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_MAX =
    HW'(HOLD_CYCLES - 1);
  localparam logic [LW-1:0] LOCK_MAX =
    LW'(LOCK_CYCLES - 1);
  localparam logic [2:0] TRIES = 3'(MAX_TRIES);

  logic [CODE_W-1:0] sw_db;
  logic              cfm_db;
  logic              set_db;
  logic              cfm_prev_q;
  logic              cfm;

  state_e            state_q, state_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic [LW-1:0]     lock_q, lock_d;
  logic [2:0]        fails_q, fails_d;
  logic [2:0]        fails_inc;
  logic [CODE_W-1:0] code_q, code_d;
  logic              yes_q, yes_d;
  logic              set_q, set_d;
  logic              endm_q, endm_d;
  logic              open_q, open_d;
  logic              lko_q, lko_d;

  // A mismatch is simply the absence of succ.
  logic unused_defeat;
  assign unused_defeat = defeat;

  genvar g;
  for (g = 0; g < CODE_W; g++) begin : g_sw
    debounce #(.DEB_CYCLES(DEB_CYCLES)) u_sw (
      .clk0     (clk0),
      .reset    (reset),
      .raw_i    (sw[g]),
      .stable_o (sw_db[g])
    );
  end

  debounce #(.DEB_CYCLES(DEB_CYCLES)) u_cfm (
    .clk0     (clk0),
    .reset    (reset),
    .raw_i    (btn_confirm),
    .stable_o (cfm_db)
  );

  debounce #(.DEB_CYCLES(DEB_CYCLES)) u_set (
    .clk0     (clk0),
    .reset    (reset),
    .raw_i    (btn_set),
    .stable_o (set_db)
  );

  assign cfm = cfm_db & ~cfm_prev_q;

  // Next state, counters and registered output values.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    lock_d    = lock_q;
    fails_d   = fails_q;
    code_d    = code_q;
    endm_d    = 1'b1;
    fails_inc = (fails_q == 3'd7) ? 3'd7 : fails_q + 3'd1;
    unique case (state_q)
      IDLE: begin
        if (cfm) begin
          code_d  = sw_db;
          hold_d  = '0;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (hold_q == HOLD_MAX) begin
          if (succ) begin
            fails_d = 3'd0;
            state_d = OPEN;
          end else begin
            fails_d = fails_inc;
            if (fails_inc == TRIES) begin
              lock_d  = '0;
              state_d = LOCKOUT;
            end else begin
              state_d = IDLE;
            end
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      OPEN: begin
        code_d = sw_db;
        if (cfm && !set_db) begin
          endm_d  = 1'b0;
          state_d = IDLE;
        end
      end
      LOCKOUT: begin
        if (lock_q == LOCK_MAX) begin
          fails_d = 3'd0;
          state_d = IDLE;
        end else begin
          lock_d = lock_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    yes_d  = (state_d != PRESENT);
    open_d = (state_d == OPEN);
    lko_d  = (state_d == LOCKOUT);
    set_d  = (state_d == OPEN) & set_db;
  end

  // State, counter and output registers.
  always_ff @(posedge clk0) begin
    if (!reset) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      lock_q     <= '0;
      fails_q    <= 3'd0;
      code_q     <= '0;
      yes_q      <= 1'b1;
      set_q      <= 1'b0;
      endm_q     <= 1'b0;
      open_q     <= 1'b0;
      lko_q      <= 1'b0;
      cfm_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      lock_q     <= lock_d;
      fails_q    <= fails_d;
      code_q     <= code_d;
      yes_q      <= yes_d;
      set_q      <= set_d;
      endm_q     <= endm_d;
      open_q     <= open_d;
      lko_q      <= lko_d;
      cfm_prev_q <= cfm_db;
    end
  end

  assign code       = code_q;
  assign yes        = yes_q;
  assign set        = set_q;
  assign endmodi    = endm_q;
  assign open       = open_q;
  assign locked_out = lko_q;
  assign fails      = fails_q;

endmodule

// File: tb/tb_key_entry.sv
// Self-checking bench for key_entry: directed table, corner
// sequences and random stimulus against a behavioural model.
module tb_key_entry;

  localparam int DEB  = 4;
  localparam int HOLD = 4;
  localparam int MAXT = 3;
  localparam int LOCK = 20;

  localparam int M_IDLE = 0;
  localparam int M_PRES = 1;
  localparam int M_OPEN = 2;
  localparam int M_LOCK = 3;

  logic       clk0 = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] sw = 4'd0;
  logic       btn_confirm = 1'b0;
  logic       btn_set = 1'b0;
  logic       succ = 1'b0;
  logic       defeat = 1'b0;
  logic [3:0] code;
  logic       yes;
  logic       set;
  logic       endmodi;
  logic       open;
  logic       locked_out;
  logic [2:0] fails;

  key_entry #(
    .DEB_CYCLES  (DEB),
    .HOLD_CYCLES (HOLD),
    .MAX_TRIES   (MAXT),
    .LOCK_CYCLES (LOCK)
  ) dut (
    .clk0        (clk0),
    .reset       (reset),
    .sw          (sw),
    .btn_confirm (btn_confirm),
    .btn_set     (btn_set),
    .succ        (succ),
    .defeat      (defeat),
    .code        (code),
    .yes         (yes),
    .set         (set),
    .endmodi     (endmodi),
    .open        (open),
    .locked_out  (locked_out),
    .fails       (fails)
  );

  always #5 clk0 = ~clk0;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  // Behavioural model: an input counts as settled when its last
  // DEB+1 synchronized samples agree; timers are plain countdowns.
  bit         hq[6][$];
  bit         mdeb[6];
  bit         mcfm_prev;
  int         mmode;
  int         mleft;
  int         mlock;
  int         mfails;
  logic [3:0] mcode;
  bit         myes, mset, mendm, mopen, mlko;

  function void model_reset();
    for (int i = 0; i < 6; i++) begin
      hq[i] = {};
      for (int j = 0; j < DEB + 3; j++) hq[i].push_back(1'b0);
      mdeb[i] = 1'b0;
    end
    mcfm_prev = 1'b0;
    mmode = M_IDLE;
    mleft = 0;
    mlock = 0;
    mfails = 0;
    mcode = 4'd0;
    myes = 1'b1;
    mset = 1'b0;
    mendm = 1'b0;
    mopen = 1'b0;
    mlko = 1'b0;
  endfunction

  function void model_edge();
    bit raw[6];
    bit cfm;
    bit exitp;
    bit eq;
    logic [3:0] swd;
    if (!reset) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 4; i++) raw[i] = sw[i];
    raw[4] = btn_confirm;
    raw[5] = btn_set;
    cfm = mdeb[4] && !mcfm_prev;
    swd = {mdeb[3], mdeb[2], mdeb[1], mdeb[0]};
    exitp = 1'b0;
    case (mmode)
      M_IDLE: begin
        if (cfm) begin
          mcode = swd;
          mleft = HOLD;
          mmode = M_PRES;
        end
      end
      M_PRES: begin
        mleft--;
        if (mleft == 0) begin
          if (succ) begin
            mfails = 0;
            mmode = M_OPEN;
          end else begin
            mfails = (mfails >= 7) ? 7 : mfails + 1;
            mlock = LOCK;
            mmode = (mfails == MAXT) ? M_LOCK : M_IDLE;
          end
        end
      end
      M_OPEN: begin
        mcode = swd;
        if (cfm && !mdeb[5]) begin
          exitp = 1'b1;
          mmode = M_IDLE;
        end
      end
      default: begin
        mlock--;
        if (mlock == 0) begin
          mfails = 0;
          mmode = M_IDLE;
        end
      end
    endcase
    myes  = (mmode != M_PRES);
    mopen = (mmode == M_OPEN);
    mlko  = (mmode == M_LOCK);
    mset  = mopen && mdeb[5];
    mendm = !exitp;
    mcfm_prev = mdeb[4];
    for (int i = 0; i < 6; i++) begin
      hq[i].push_back(raw[i]);
      void'(hq[i].pop_front());
      eq = 1'b1;
      for (int j = 1; j <= DEB; j++)
        if (hq[i][j] != hq[i][0]) eq = 1'b0;
      if (eq) mdeb[i] = hq[i][0];
    end
  endfunction

  task automatic check_model();
    compared++;
    if (code !== mcode || yes !== myes || set !== mset ||
        endmodi !== mendm || open !== mopen ||
        locked_out !== mlko || fails !== 3'(mfails)) begin
      mismatched++;
      $display("FAIL model cyc=%0d got c=%h y=%b s=%b e=%b o=%b l=%b f=%0d want c=%h y=%b s=%b e=%b o=%b l=%b f=%0d",
               cyc, code, yes, set, endmodi, open, locked_out,
               fails, mcode, myes, mset, mendm, mopen, mlko,
               mfails);
    end
  endtask

  task automatic step();
    @(posedge clk0);
    model_edge();
    #1;
    check_model();
    cyc++;
  endtask

  typedef struct {
    string      nm;
    logic [3:0] sw;
    logic       bc, bs, sc, df;
    int         n;
    logic [3:0] code;
    logic       yes, set, endm, open, lko;
    logic [2:0] fails;
  } vec_t;

  vec_t tv[$];

  function void add(input string nm, input logic [3:0] s,
                    input logic bc, bs, sc, df, input int n,
                    input logic [3:0] c,
                    input logic y, st, e, o, l,
                    input logic [2:0] f);
    vec_t v;
    v.nm = nm; v.sw = s; v.bc = bc; v.bs = bs;
    v.sc = sc; v.df = df; v.n = n; v.code = c;
    v.yes = y; v.set = st; v.endm = e; v.open = o;
    v.lko = l; v.fails = f;
    tv.push_back(v);
  endfunction

  task automatic expect_out(input string nm, input logic [3:0] c,
                            input logic y, st, e, o, l,
                            input logic [2:0] f);
    compared++;
    if ({code, yes, set, endmodi, open, locked_out, fails} !==
        {c, y, st, e, o, l, f}) begin
      mismatched++;
      $display("FAIL %s got c=%h y=%b s=%b e=%b o=%b l=%b f=%0d want c=%h y=%b s=%b e=%b o=%b l=%b f=%0d",
               nm, code, yes, set, endmodi, open, locked_out,
               fails, c, y, st, e, o, l, f);
    end
  endtask

  int entries;
  int first_at;
  logic prev_yes;
  int len;

  initial begin
    model_reset();
    //  name          sw     bc bs sc df  n  code  y s e o l f
    add("idle",       4'h0,  0, 0, 0, 0, 10, 4'h0, 1,0,1,0,0,0);
    add("ok_press",   4'hA,  1, 0, 0, 0,  8, 4'hA, 0,0,1,0,0,0);
    add("ok_open",    4'hA,  0, 0, 1, 0, 10, 4'hA, 1,0,1,1,0,0);
    add("prog_set",   4'h6,  0, 1, 1, 0, 10, 4'h6, 1,1,1,1,0,0);
    add("prog_rel",   4'h6,  0, 0, 0, 0, 10, 4'h6, 1,0,1,1,0,0);
    add("close",      4'h6,  1, 0, 0, 0,  8, 4'h6, 1,0,0,0,0,0);
    add("close_next", 4'h6,  0, 0, 0, 0,  1, 4'h6, 1,0,1,0,0,0);
    add("settle1",    4'h6,  0, 0, 0, 0, 10, 4'h6, 1,0,1,0,0,0);
    add("bad1_press", 4'h1,  1, 0, 0, 0,  8, 4'h1, 0,0,1,0,0,0);
    add("bad1",       4'h1,  0, 0, 0, 1, 10, 4'h1, 1,0,1,0,0,1);
    add("bad2_press", 4'h1,  1, 0, 0, 0,  8, 4'h1, 0,0,1,0,0,1);
    add("bad2",       4'h1,  0, 0, 0, 1, 10, 4'h1, 1,0,1,0,0,2);
    add("bad3_press", 4'h1,  1, 0, 0, 0,  8, 4'h1, 0,0,1,0,0,2);
    add("bad3_lock",  4'h1,  0, 0, 0, 1, 10, 4'h1, 1,0,1,0,1,3);
    add("lock_press", 4'h1,  1, 0, 0, 0,  8, 4'h1, 1,0,1,0,1,3);
    add("lock_end",   4'h1,  1, 0, 0, 0,  8, 4'h1, 1,0,1,0,0,0);
    add("settle2",    4'h1,  0, 0, 0, 0, 10, 4'h1, 1,0,1,0,0,0);
    add("none_press", 4'h3,  1, 0, 0, 0,  8, 4'h3, 0,0,1,0,0,0);
    add("no_verdict", 4'h3,  0, 0, 0, 0, 10, 4'h3, 1,0,1,0,0,1);
    add("both_press", 4'h3,  1, 0, 0, 0,  8, 4'h3, 0,0,1,0,0,1);
    add("both_open",  4'h3,  0, 0, 1, 1, 10, 4'h3, 1,0,1,1,0,0);
    add("both_close", 4'h3,  1, 0, 0, 0,  8, 4'h3, 1,0,0,0,0,0);
    add("settle3",    4'h3,  0, 0, 0, 0, 10, 4'h3, 1,0,1,0,0,0);

    reset = 1'b0;
    repeat (3) step();
    expect_out("reset", 4'h0, 1, 0, 0, 0, 0, 3'd0);
    reset = 1'b1;

    foreach (tv[i]) begin
      sw = tv[i].sw;
      btn_confirm = tv[i].bc;
      btn_set = tv[i].bs;
      succ = tv[i].sc;
      defeat = tv[i].df;
      repeat (tv[i].n) step();
      expect_out(tv[i].nm, tv[i].code, tv[i].yes, tv[i].set,
                 tv[i].endm, tv[i].open, tv[i].lko, tv[i].fails);
    end

    // Reset in the middle of a confirm window with fails nonzero.
    sw = 4'h5; btn_confirm = 1'b1; succ = 1'b0; defeat = 1'b1;
    repeat (8) step();
    btn_confirm = 1'b0;
    repeat (10) step();
    btn_confirm = 1'b1;
    repeat (8) step();
    expect_out("pre_reset", 4'h5, 0, 0, 1, 0, 0, 3'd1);
    reset = 1'b0;
    btn_confirm = 1'b0;
    step();
    expect_out("reset_mid", 4'h0, 1, 0, 0, 0, 0, 3'd0);
    reset = 1'b1;
    step();
    expect_out("after_reset", 4'h0, 1, 0, 1, 0, 0, 3'd0);
    repeat (10) step();

    // Bouncing confirm: only the settled press opens a window.
    succ = 1'b0; defeat = 1'b0; sw = 4'h9;
    entries = 0;
    first_at = -1;
    prev_yes = yes;
    for (int i = 0; i < 40; i++) begin
      btn_confirm = (i < 10) ? (((i / 2) % 2) == 0) : 1'b1;
      step();
      if (prev_yes === 1'b1 && yes === 1'b0) begin
        entries++;
        if (first_at < 0) first_at = i;
      end
      prev_yes = yes;
    end
    compared++;
    if (entries != 1) begin
      mismatched++;
      $display("FAIL bounce_count got %0d want 1", entries);
    end
    compared++;
    if (first_at != 15) begin
      mismatched++;
      $display("FAIL bounce_latency got %0d want 15", first_at);
    end
    btn_confirm = 1'b0;
    repeat (10) step();

    // Random traffic against the model.
    repeat (350) begin
      sw = 4'($urandom);
      btn_confirm = 1'($urandom);
      btn_set = ($urandom_range(0, 3) == 0);
      len = $urandom_range(1, 12);
      for (int j = 0; j < len; j++) begin
        succ = 1'($urandom);
        defeat = 1'($urandom);
        reset = ($urandom_range(0, 399) != 0);
        step();
      end
    end
    reset = 1'b1;
    repeat (5) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/key_entry.md
Name: key_entry

Overview:
- Code-entry front end that drives the e-lock comparator's input interface: code nibble, active-low confirm (`yes`), `set`, `endmodi`.
- Consumes the comparator's `succ`/`defeat` verdict.
- Debounces four code switches and two push buttons, and presents each attempt as a timed confirm window.
- Counts failed attempts and enforces a timed lockout; code re-programming is permitted only while open.
- Sits between the board switches/buttons and the comparator.

Parameters:
- DEB_CYCLES, 1000, clk0 cycles an input must be stable before its debounced value updates.
- HOLD_CYCLES, 4, cycles `yes` is held low per attempt; verdict is sampled on the last one (must be ≥2).
- MAX_TRIES, 3, consecutive failures that trigger lockout (1..7).
- LOCK_CYCLES, 50000, lockout duration in clk0 cycles.

Ports:
- clk0  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-low reset.
- sw  in  4  raw code switches; sw[0] drives code[0].
- btn_confirm  in  1  raw confirm button, active-high.
- btn_set  in  1  raw program button, active-high.
- succ  in  1  comparator verdict: match.
- defeat  in  1  comparator verdict: mismatch.
- code  out  4  frozen code presented to the comparator.
- yes  out  1  active-low confirm to the comparator.
- set  out  1  program strobe to the comparator.
- endmodi  out  1  active-low end-of-modify to the comparator.
- open  out  1  lock-open indicator.
- locked_out  out  1  lockout indicator.
- fails  out  3  current consecutive-failure count.

Behaviour:
- Reset (reset=0 at a clk0 edge), all outputs: code=0, yes=1, set=0, endmodi=0, open=0, locked_out=0, fails=0, state=IDLE. Debounced values cleared to 0, counters cleared. Reset overrides any state, including mid-PRESENT and mid-LOCKOUT.
- Debounce, per input:
  - The counter restarts whenever the raw input differs from the last raw sample.
  - The debounced value takes the raw value once the counter reaches DEB_CYCLES-1.
  - The synchronizer is 2 flops ahead of the debouncer.
  - Rising-edge detect on debounced btn_confirm yields a 1-cycle `cfm` pulse.
- FSM states: IDLE, PRESENT, OPEN, LOCKOUT.
- IDLE:
  - yes=1, endmodi=1, set=0.
  - On `cfm`: code is loaded from the debounced sw, the hold counter is cleared, and the FSM goes to PRESENT.
  - code is stable for the entire PRESENT state.
- PRESENT:
  - yes=0 for exactly HOLD_CYCLES cycles.
  - On the last cycle, succ/defeat are sampled:
    - succ=1 → OPEN, fails←0.
    - succ=0 (defeat=1, or both 0) → fails←fails+1. If the new value equals MAX_TRIES → LOCKOUT, else → IDLE.
    - succ=1 together with defeat=1 → treated as succ.
  - `cfm` is ignored during PRESENT.
  - yes returns to 1 on the cycle after the sample.
- OPEN:
  - open=1, endmodi=1.
  - set = debounced btn_set, registered.
  - code tracks debounced sw every cycle, so the comparator captures the new code while set=1.
  - On `cfm` (with debounced btn_set=0): endmodi=0 for 1 cycle, then IDLE, open=0. With btn_set=1, `cfm` is ignored.
- LOCKOUT:
  - locked_out=1, yes=1.
  - `cfm` is ignored; button presses do not extend the timer.
  - After LOCK_CYCLES cycles: fails←0 and the FSM goes to IDLE.
- Widths:
  - Debounce and lockout counters are sized by $clog2 of their parameter.
  - fails saturates at 7.
  - All counters wrap-free: each is cleared on entering its state.

Decomposition:
- Shared package `elock_pkg`:
  - FSM state enum (IDLE, PRESENT, OPEN, LOCKOUT).
  - Default DEB_CYCLES, HOLD_CYCLES, MAX_TRIES, LOCK_CYCLES constants.
  - Code width 4.
- Sub-module `debounce`, parameterized by DEB_CYCLES, instantiated 6 times (4 sw, confirm, set).
  - Includes the 2-flop synchronizer.
  - Outputs the stable level.

Test Plan (DEB_CYCLES=4, HOLD_CYCLES=4, MAX_TRIES=3, LOCK_CYCLES=20):
1. Reset mid-PRESENT: pull reset=0 for 1 cycle while yes=0 → next cycle yes=1, code=0, fails=0, state IDLE.
2. Correct code: sw=4'b1010, press confirm, model succ=1 → yes low exactly 4 cycles, code=4'b1010 throughout, then open=1, fails=0.
3. Three wrong attempts, defeat=1 each → fails goes 1, 2, then locked_out=1. Confirm presses during lockout produce no yes pulse. After 20 cycles: locked_out=0, fails=0.
4. Bounce: toggle btn_confirm every 2 cycles for 10 cycles, then hold high → exactly one PRESENT entry, after the input has been stable for 4 cycles plus 2 sync cycles.
5. Program while open: from OPEN, sw=4'b0110, hold btn_set → set=1, code=4'b0110. Release, then confirm → endmodi=0 for 1 cycle, open=0, IDLE.
6. No verdict: succ=0, defeat=0 at the sample cycle → counted as a failure, fails increments by 1, state IDLE.
